// File: rtl/min_receive_fsm.sv
// -----------------------------------------------------------------------------
// min_receive_fsm
//
// Receive side of the MIN serial framing protocol. Consumes the UART RX byte
// stream, detects the AA AA AA header, removes stuff bytes, tracks the frame
// fields (ID, LEN, payload, CRC, EOF) and presents each good frame as one
// parallel word. Runs entirely in the sclk domain.
//
// Build option:
//   MIN_RX_CRC_CHECK_EN  defined   : CRC-32 is computed and checked.
//                        undefined : CRC bytes are consumed but ignored.
//
// Ports:
//   i_clk    sclk, all logic on the rising edge
//   i_rst    synchronous active-high reset
//   i_en     when low, i_valid is ignored and all state holds
//   i_valid  one-cycle strobe, i_data carries a received byte
//   i_data   received byte
//   o_valid  one-cycle pulse, a good frame is on o_id/o_len/o_data
//   o_err    one-cycle pulse, frame rejected
//   o_busy   high from the first post-header byte until the frame ends
//   o_id     ID/control byte of the last accepted frame
//   o_len    payload length of the last accepted frame
//   o_data   payload of the last accepted frame, byte 0 in [7:0], unused = 0
// -----------------------------------------------------------------------------
module min_receive_fsm #(
  parameter int          MAX_PAYLOAD = 8,
  parameter logic [7:0]  HDR_BYTE    = 8'hAA,
  parameter logic [7:0]  STUFF_BYTE  = 8'h55
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [7:0]               i_data,
  output logic                     o_valid,
  output logic                     o_err,
  output logic                     o_busy,
  output logic [7:0]               o_id,
  output logic [7:0]               o_len,
  output logic [8*MAX_PAYLOAD-1:0] o_data
);

  localparam int IDXW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID,
    S_LEN,
    S_PAYLOAD,
    S_CRC3,
    S_CRC2,
    S_CRC1,
    S_CRC0,
    S_EOF
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [1:0]               r_hdr_cnt;
  logic [1:0]               w_hdr_cnt_nxt;
  logic                     w_strobe;
  logic                     w_resync;   // third consecutive header byte
  logic                     w_take;     // byte is frame content, not stuffing
  logic                     w_accept;
  logic                     w_reject;
  logic                     w_crc_ok;

  // Shadow copy of the frame under reception
  logic [7:0]               r_id_sh;
  logic [7:0]               r_len_sh;
  logic [7:0]               r_idx;
  logic [7:0]               r_shadow [MAX_PAYLOAD];

  logic                     r_valid;
  logic                     r_err;
  logic [7:0]               r_id;
  logic [7:0]               r_len;
  logic [8*MAX_PAYLOAD-1:0] r_data;

  assign w_strobe = i_en && i_valid;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_hdr_cnt <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_hdr_cnt <= w_hdr_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, including header detection and unstuffing
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_hdr_cnt_nxt = r_hdr_cnt;
    w_resync      = 1'b0;
    w_take        = 1'b0;
    w_accept      = 1'b0;
    w_reject      = 1'b0;

    if (w_strobe) begin
      if (i_data == HDR_BYTE) begin
        if (r_hdr_cnt == 2'd2) begin
          // Header resync wins in every state; abort any frame in flight.
          w_resync      = 1'b1;
          w_reject      = (r_state != S_IDLE);
          w_state_nxt   = S_ID;
          w_hdr_cnt_nxt = 2'd0;
        end else begin
          w_hdr_cnt_nxt = r_hdr_cnt + 2'd1;
        end
      end else begin
        w_hdr_cnt_nxt = 2'd0;
      end

      if (!w_resync && (r_state != S_IDLE)) begin
        if (r_hdr_cnt == 2'd2) begin
          // Byte after HDR HDR inside a frame: only a stuff byte is legal,
          // and it carries no content.
          if (i_data != STUFF_BYTE) begin
            w_reject    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_take = 1'b1;
          unique case (r_state)
            S_ID:      w_state_nxt = S_LEN;
            S_LEN: begin
              if (i_data > 8'(MAX_PAYLOAD)) begin
                w_reject    = 1'b1;
                w_state_nxt = S_IDLE;
              end else if (i_data == 8'd0) begin
                w_state_nxt = S_CRC3;
              end else begin
                w_state_nxt = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              if ((r_idx + 8'd1) == r_len_sh) w_state_nxt = S_CRC3;
            end
            S_CRC3:    w_state_nxt = S_CRC2;
            S_CRC2:    w_state_nxt = S_CRC1;
            S_CRC1:    w_state_nxt = S_CRC0;
            S_CRC0:    w_state_nxt = S_EOF;
            S_EOF: begin
              w_state_nxt = S_IDLE;
              if ((i_data == STUFF_BYTE) && w_crc_ok) w_accept = 1'b1;
              else                                    w_reject = 1'b1;
            end
            default:   w_state_nxt = S_IDLE;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Busy covers LEN through EOF, so it drops in the same cycle a result pulses
  // (state is IDLE or, after a resync, ID).
  always_comb begin
    o_busy = !((r_state == S_IDLE) || (r_state == S_ID));
  end

  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_id    = r_id;
  assign o_len   = r_len;
  assign o_data  = r_data;

  // ---------------------------------------------------------------------------
  // Frame datapath: shadow capture and output load
  // ---------------------------------------------------------------------------
  // NOTE: the shadow buffer is reset (and cleared on every header) because
  // unused payload bytes must read back as zero on o_data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_id     <= 8'd0;
      r_len    <= 8'd0;
      r_data   <= '0;
      r_id_sh  <= 8'd0;
      r_len_sh <= 8'd0;
      r_idx    <= 8'd0;
      for (int i = 0; i < MAX_PAYLOAD; i++) r_shadow[i] <= 8'd0;
    end else begin
      r_valid <= w_accept;
      r_err   <= w_reject;

      if (w_resync) begin
        r_id_sh  <= 8'd0;
        r_len_sh <= 8'd0;
        r_idx    <= 8'd0;
        for (int i = 0; i < MAX_PAYLOAD; i++) r_shadow[i] <= 8'd0;
      end else if (w_take) begin
        case (r_state)
          S_ID:  r_id_sh <= i_data;
          S_LEN: begin
            r_len_sh <= i_data;
            r_idx    <= 8'd0;
          end
          S_PAYLOAD: begin
            r_shadow[r_idx[IDXW-1:0]] <= i_data;
            r_idx                     <= r_idx + 8'd1;
          end
          default: ;
        endcase
      end

      if (w_accept) begin
        r_id  <= r_id_sh;
        r_len <= r_len_sh;
        for (int i = 0; i < MAX_PAYLOAD; i++) r_data[i*8 +: 8] <= r_shadow[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CRC-32 (reflected 0xEDB88320, init and final XOR all ones)
  // ---------------------------------------------------------------------------
`ifdef MIN_RX_CRC_CHECK_EN
  logic [31:0] r_crc;
  logic [31:0] r_rx_crc;
  logic [31:0] w_crc_nxt;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign w_crc_nxt = crc32_byte(r_crc, i_data);
  // Received CRC is big-endian over the wire; compare after the final XOR.
  assign w_crc_ok  = ((r_crc ^ 32'hFFFFFFFF) == r_rx_crc);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_crc    <= 32'hFFFFFFFF;
      r_rx_crc <= 32'd0;
    end else if (w_resync) begin
      r_crc    <= 32'hFFFFFFFF;
    end else if (w_take) begin
      case (r_state)
        S_ID, S_LEN, S_PAYLOAD:         r_crc    <= w_crc_nxt;
        S_CRC3, S_CRC2, S_CRC1, S_CRC0: r_rx_crc <= {r_rx_crc[23:0], i_data};
        default: ;
      endcase
    end
  end
`else
  assign w_crc_ok = 1'b1;
`endif

endmodule

// File: tb/tb_min_receive_fsm.sv
// -----------------------------------------------------------------------------
// tb_min_receive_fsm
//
// Self-checking bench for min_receive_fsm. Frames are built at the frame
// level (ID, payload, CRC-32, transmit-side stuffing) and the expected result
// of each frame follows from what was built: good frames update the expected
// output word, damaged frames must raise o_err and leave it untouched.
// -----------------------------------------------------------------------------
module tb_min_receive_fsm;

  localparam int MAXP = 8;
  localparam logic [7:0] HDR = 8'hAA;
  localparam logic [7:0] STF = 8'h55;

`ifdef MIN_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_en;
  logic              i_valid;
  logic [7:0]        i_data;
  logic              o_valid;
  logic              o_err;
  logic              o_busy;
  logic [7:0]        o_id;
  logic [7:0]        o_len;
  logic [8*MAXP-1:0] o_data;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0]  exp_id   = 8'd0;
  logic [7:0]  exp_len  = 8'd0;
  logic [63:0] exp_data = 64'd0;

  min_receive_fsm #(.MAX_PAYLOAD(MAXP)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_err   (o_err),
    .o_busy  (o_busy),
    .o_id    (o_id),
    .o_len   (o_len),
    .o_data  (o_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Standard reflected CRC-32 over a byte sequence.
  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'd0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // One byte presented for one clock; outputs are sampled 1 ns after the edge.
  task automatic strobe(input logic [7:0] b, input logic en);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_en    = en;
    i_data  = b;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      i_en    = 1'b1;
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "/id"},   o_id,   exp_id);
    chk({tag, "/len"},  o_len,  exp_len);
    chk({tag, "/data"}, o_data, exp_data);
  endtask

  function automatic logic [7:0] rand_byte();
    return ($urandom_range(0, 2) == 0) ? HDR : 8'($urandom);
  endfunction

  // Builds and sends one complete frame, checking o_valid/o_err after every
  // byte. resync_err: an unfinished frame precedes this one, so its third
  // header byte must raise o_err. en_gap: two disabled strobes are slipped in
  // after the first payload byte.
  task automatic send_frame(input logic [7:0] id, input logic [7:0] pl[$],
                            input bit bad_crc, input bit bad_eof,
                            input bit resync_err, input bit en_gap,
                            input string tag);
    logic [7:0]  body[$];
    logic [7:0]  q[$];
    logic [31:0] crc;
    logic [7:0]  b;
    int          run;
    bit          good;
    bit          last;

    body.push_back(id);
    body.push_back(8'(pl.size()));
    foreach (pl[i]) body.push_back(pl[i]);
    crc = crc32(body);
    body.push_back(crc[31:24]);
    body.push_back(crc[23:16]);
    body.push_back(crc[15:8]);
    body.push_back(bad_crc ? (crc[7:0] ^ 8'h01) : crc[7:0]);

    q = '{HDR, HDR, HDR};
    run = 0;
    foreach (body[i]) begin
      q.push_back(body[i]);
      run = (body[i] == HDR) ? run + 1 : 0;
      if (run == 2) begin
        q.push_back(STF);
        run = 0;
      end
    end
    if (bad_eof) begin
      do b = 8'($urandom); while (b == STF || b == HDR);
      q.push_back(b);
    end else begin
      q.push_back(STF);
    end

    good = !bad_eof && !(bad_crc && CRC_EN);

    for (int i = 0; i < q.size(); i++) begin
      if (en_gap && i == 6) begin
        strobe(8'($urandom), 1'b0);
        chk({tag, "/gap_valid"}, o_valid, 1'b0);
        strobe(8'($urandom), 1'b0);
        chk({tag, "/gap_err"}, o_err, 1'b0);
      end
      strobe(q[i], 1'b1);
      last = (i == q.size() - 1);
      chk($sformatf("%s/valid[%0d]", tag, i), o_valid, last && good);
      chk($sformatf("%s/err[%0d]", tag, i), o_err,
          (last && !good) || (resync_err && i == 2));
      if (i == 3) chk({tag, "/busy_mid"}, o_busy, 1'b1);
      if (last)   chk({tag, "/busy_end"}, o_busy, 1'b0);
    end

    if (good) begin
      exp_id   = id;
      exp_len  = 8'(pl.size());
      exp_data = 64'd0;
      foreach (pl[i]) exp_data[i*8 +: 8] = pl[i];
    end
    chk_held(tag);
  endtask

  initial begin
    logic [7:0] pl[$];
    bit         bc;
    bit         be;

    i_rst   = 1'b1;
    i_en    = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'd0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset/valid", o_valid, 1'b0);
    chk("reset/err",   o_err,   1'b0);
    chk("reset/busy",  o_busy,  1'b0);
    chk_held("reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    idle(1);

    // Basic good frame
    pl = '{8'h12, 8'h34};
    send_frame(8'h01, pl, 1'b0, 1'b0, 1'b0, 1'b0, "good");
    chk("good/data16", {48'd0, o_data[15:0]}, 64'h3412);

    // Payload needing stuffing, sent back-to-back
    pl = '{8'hAA, 8'hAA, 8'h07};
    send_frame(8'h02, pl, 1'b0, 1'b0, 1'b0, 1'b0, "stuff");
    chk("stuff/data24", {40'd0, o_data[23:0]}, 64'h07AAAA);

    // Corrupt CRC: rejected only when CRC checking is built in
    idle(2);
    pl = '{8'h05, 8'h06, 8'h07};
    send_frame(8'h03, pl, 1'b1, 1'b0, 1'b0, 1'b0, "badcrc");

    // Wrong EOF byte
    pl = '{8'h61};
    send_frame(8'h04, pl, 1'b0, 1'b1, 1'b0, 1'b0, "badeof");

    // Overlength LEN, then a normal frame
    strobe(HDR, 1'b1);
    strobe(HDR, 1'b1);
    strobe(HDR, 1'b1);
    strobe(8'h05, 1'b1);
    chk("ovl/err_id", o_err, 1'b0);
    strobe(8'd9, 1'b1);
    chk("ovl/err", o_err, 1'b1);
    chk("ovl/valid", o_valid, 1'b0);
    chk("ovl/busy", o_busy, 1'b0);
    chk_held("ovl");
    idle(1);
    chk("ovl/err_once", o_err, 1'b0);
    pl = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78};
    send_frame(8'h06, pl, 1'b0, 1'b0, 1'b0, 1'b0, "ovl_next");

    // Resync: unfinished frame, then a complete frame
    strobe(HDR, 1'b1);
    strobe(HDR, 1'b1);
    strobe(HDR, 1'b1);
    strobe(8'h11, 1'b1);
    strobe(8'h04, 1'b1);
    strobe(8'h21, 1'b1);
    strobe(8'h22, 1'b1);
    pl = '{8'h31, 8'h32, 8'h33};
    send_frame(8'h12, pl, 1'b0, 1'b0, 1'b1, 1'b0, "resync");

    // Disabled strobes inside the payload are ignored
    idle(1);
    pl = '{8'h41, 8'h42, 8'h43, 8'h44};
    send_frame(8'h13, pl, 1'b0, 1'b0, 1'b0, 1'b1, "en_gap");

    // Reset mid-frame discards the frame silently
    strobe(HDR, 1'b1);
    strobe(HDR, 1'b1);
    strobe(HDR, 1'b1);
    strobe(8'h33, 1'b1);
    strobe(8'h03, 1'b1);
    strobe(8'h44, 1'b1);
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    exp_id   = 8'd0;
    exp_len  = 8'd0;
    exp_data = 64'd0;
    chk("rst/valid", o_valid, 1'b0);
    chk("rst/err",   o_err,   1'b0);
    chk("rst/busy",  o_busy,  1'b0);
    chk_held("rst");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    chk("rst/err_after", o_err, 1'b0);
    pl = '{8'h5A};
    send_frame(8'h14, pl, 1'b0, 1'b0, 1'b0, 1'b0, "rst_next");

    // Random frames, header-heavy payloads, random gaps
    for (int f = 0; f < 40; f++) begin
      pl = {};
      for (int i = 0; i < $urandom_range(0, MAXP); i++) pl.push_back(rand_byte());
      bc = ($urandom_range(0, 5) == 0);
      be = ($urandom_range(0, 5) == 0);
      send_frame(rand_byte(), pl, bc, be, 1'b0, 1'b0, $sformatf("rnd%0d", f));
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/min_receive_fsm.md
Name: min_receive_fsm

Overview:
- Receives the MIN serial framing protocol on the UART RX byte stream. This is the mirror of the existing MIN transmit path that streams I/Q packets.
- Strips stuff bytes, validates the frame and presents the ID, length and payload as one parallel word.
- Sits between the UART receiver (RS232_RX) and the command/configuration logic, in the sclk domain.

Parameters:
- MAX_PAYLOAD, 8: maximum payload bytes held; o_data width is 8*MAX_PAYLOAD.
- HDR_BYTE, 8'hAA: header/stuffing marker byte.
- STUFF_BYTE, 8'h55: stuff byte; also the EOF byte.

Ports:
- i_clk  in  1  sclk; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  when low, i_valid is ignored and all state is held.
- i_valid  in  1  one-cycle strobe: i_data carries a received byte.
- i_data  in  8  received byte.
- o_valid  out  1  one-cycle pulse: a good frame is on o_id/o_len/o_data.
- o_err  out  1  one-cycle pulse: frame rejected.
- o_busy  out  1  high from the first post-header byte until the frame ends.
- o_id  out  8  ID/control byte of the last accepted frame.
- o_len  out  8  payload length of the last accepted frame.
- o_data  out  8*MAX_PAYLOAD  payload of the last accepted frame; byte 0 in bits [7:0]; unused bytes are 0.

Behaviour:
- Reset: o_valid=0, o_err=0, o_busy=0, o_id=0, o_len=0, o_data=0; state=IDLE; header counter=0; CRC register=32'hFFFFFFFF.
- Only cycles with i_en && i_valid advance anything.
- Header detection runs in every state:
  - A counter tracks consecutive HDR_BYTE values.
  - A third consecutive HDR_BYTE always resynchronises: state=ID, CRC reinitialised, shadow buffer cleared.
  - If a frame was in progress at resync, o_err pulses.
- Unstuffing:
  - In ID..EOF states, a byte following two consecutive HDR_BYTE values is inspected.
  - STUFF_BYTE: discarded, counter cleared, no state advance.
  - HDR_BYTE: header resync, as above.
  - Any other value: o_err, return to IDLE.
- States (one unstuffed byte per transition):
  - IDLE: waits for a header.
  - ID: capture the ID.
  - LEN:
    - LEN > MAX_PAYLOAD: o_err, go to IDLE.
    - LEN = 0: go to CRC3.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD: store bytes at increasing index; after LEN bytes, go to CRC3.
  - CRC3..CRC0: shift in the received CRC, big-endian.
  - EOF: byte must equal STUFF_BYTE, then accept or reject.
- CRC:
  - CRC-32, reflected polynomial 32'hEDB88320, init all ones, final XOR all ones.
  - Computed over ID, LEN and payload after unstuffing.
  - Byte-wise combinational update, registered once per byte.
- Accept:
  - Condition: EOF byte correct and CRC matches.
  - o_id, o_len and o_data load from the shadow buffer.
  - o_valid pulses the cycle after the EOF strobe; latency is 1 clock.
  - Outputs stay stable until the next accept.
- Reject:
  - Conditions: EOF byte wrong, CRC mismatch, overlength, or illegal byte after HDR HDR.
  - o_err pulses the cycle after the offending strobe; outputs are unchanged; return to IDLE.
- o_busy falls in the same cycle that o_valid or o_err pulses.
- o_valid and o_err are never asserted together.
- Reset mid-frame: the partial frame is discarded with no o_err.
- Back-to-back frames with no idle bytes between them are supported. Strobes on consecutive clocks are supported.

Optional Feature:
- MIN_RX_CRC_CHECK_EN defined:
  - CRC is computed and compared as above.
- Not defined:
  - CRC logic is omitted entirely.
  - The four CRC bytes are consumed (unstuffed) but ignored.
  - Accept requires only a correct EOF byte.
  - CRC mismatch never causes o_err.

Test Plan:
- Good frame: AA AA AA 01 02 12 34 + CRC (bench model) + 55 → o_valid one cycle after the 55; o_id=01, o_len=02, o_data[15:0]=16'h3412, upper bytes 0; o_err=0.
- Stuffing: payload AA AA 07 sent as AA AA 55 07 → o_len=03, o_data[23:0]=24'h07AAAA, CRC valid; stuff byte is not counted in the length.
- Corrupt CRC: last CRC byte flipped → o_err pulse, o_valid=0, previous o_data retained. Without MIN_RX_CRC_CHECK_EN, the same frame gives o_valid.
- Overlength: LEN=09 with MAX_PAYLOAD=8 → o_err the cycle after the LEN byte; then a good frame is accepted normally.
- Resync: header + ID + LEN 04 + two payload bytes, then AA AA AA and a complete good frame → o_err at the resync, then o_valid with the second frame's values.
- i_en/reset: i_en low during the middle two payload strobes → those bytes are ignored and the frame completes with the later bytes. i_rst pulse mid-frame → all outputs 0, no o_err, next frame accepted.
